multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/controller_pkg.sv | 62 ++++++
 rtl/cond_unit.sv | 37 +++
 rtl/multicycle_controller.sv | 162 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU control
// codes, decoded fields and the condition-code evaluator.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE;

  // flags packed as {N,Z,C,V}; cond 1111 (and anything unlisted) is false
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      C_EQ:    return z;
      C_NE:    return !z;
      C_CS:    return c;
      C_CC:    return !c;
      C_MI:    return n;
      C_PL:    return !n;
      C_VS:    return v;
      C_VC:    return !v;
      C_HI:    return c & !z;
      C_LS:    return !c | z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return !z & (n == v);
      C_LE:    return z | (n != v);
      C_AL:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Flags register plus registered condition-pass bit for the multicycle controller.
module cond_unit
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_decode,
  input  logic       i_flag_we,
  input  logic       i_cv_we,
  output logic       o_cond_ok
);

  logic [3:0] r_flags;
  logic       r_cond_ok;

  // cond_ok is sampled once per instruction in DECODE and gates every
  // later strobe, including the flag update itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags   <= 4'b0000;
      r_cond_ok <= 1'b0;
    end else begin
      if (i_decode)
        r_cond_ok <= cond_eval(i_cond, r_flags);
      if (i_flag_we && r_cond_ok) begin
        r_flags[3:2] <= i_alu_flags[3:2];
        if (i_cv_we)
          r_flags[1:0] <= i_alu_flags[1:0];
      end
    end
  end

  assign o_cond_ok = r_cond_ok;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute and
// drives datapath selects and write strobes as Moore outputs.
module multicycle_controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   state_o
);

  state_t     r_state, w_next;
  logic [3:0] w_cond, w_cmd;
  logic [1:0] w_op, w_dp_alu;
  logic       w_i, w_s, w_u, w_rd15, w_cond_ok, w_unused_rn;

  assign w_cond      = Instr[31:28];
  assign w_op        = Instr[27:26];
  assign w_i         = Instr[25];
  assign w_cmd       = Instr[24:21];
  assign w_s         = Instr[20];
  assign w_u         = Instr[23];
  assign w_rd15      = (Instr[15:12] == 4'hF);
  assign w_unused_rn = ^Instr[19:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_DP:   w_next = w_i ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  w_next = S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = w_s ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (w_cmd)
      CMD_ADD: w_dp_alu = ALU_ADD;
      CMD_SUB: w_dp_alu = ALU_SUB;
      CMD_AND: w_dp_alu = ALU_AND;
      CMD_ORR: w_dp_alu = ALU_ORR;
      default: w_dp_alu = ALU_ADD;
    endcase
  end

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_decode    (r_state == S_DECODE),
    .i_flag_we   (((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) && w_s),
    .i_cv_we     ((w_cmd == CMD_ADD) || (w_cmd == CMD_SUB)),
    .o_cond_ok   (w_cond_ok)
  );

  logic       w_pcw, w_mw, w_rw, w_irw, w_adr, w_srca;
  logic [1:0] w_res, w_srcb, w_imm, w_aluc, w_regsrc;

  always_comb begin
    w_pcw  = 1'b0;
    w_mw   = 1'b0;
    w_rw   = 1'b0;
    w_irw  = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_res  = 2'b00;
    w_srcb = 2'b00;
    w_imm  = 2'b00;
    w_aluc = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_res  = 2'b10;
        w_pcw  = 1'b1;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_res  = 2'b10;
      end
      S_MEMADR: begin
        w_srcb = 2'b01;
        w_imm  = 2'b01;
        w_aluc = w_u ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD:  w_adr = 1'b1;
      S_MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = w_cond_ok;
      end
      S_MEMWB: begin
        w_res = 2'b01;
        w_rw  = w_cond_ok;
        w_pcw = w_cond_ok & w_rd15;
      end
      S_EXECUTER: w_aluc = w_dp_alu;
      S_EXECUTEI: begin
        w_srcb = 2'b01;
        w_aluc = w_dp_alu;
      end
      S_ALUWB: begin
        w_rw  = w_cond_ok;
        w_pcw = w_cond_ok & w_rd15;
      end
      S_BRANCH: begin
        w_srcb = 2'b01;
        w_imm  = 2'b10;
        w_res  = 2'b10;
        w_pcw  = w_cond_ok;
      end
      default: ;
    endcase
  end

  assign w_regsrc = {(w_op == OP_MEM) && !w_s, w_op == OP_BR};

  // Outputs are forced low while reset is held, not just after the
  // asynchronous state clear, so FETCH strobes never leak during reset.
  assign PCWrite    = reset & w_pcw;
  assign MemWrite   = reset & w_mw;
  assign RegWrite   = reset & w_rw;
  assign IRWrite    = reset & w_irw;
  assign AdrSrc     = reset & w_adr;
  assign ALUSrcA    = reset & w_srca;
  assign ResultSrc  = {2{reset}} & w_res;
  assign ALUSrcB    = {2{reset}} & w_srcb;
  assign ImmSrc     = {2{reset}} & w_imm;
  assign RegSrc     = {2{reset}} & w_regsrc;
  assign ALUControl = {2{reset}} & w_aluc;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push
// per-cycle expected outputs; a negedge monitor pops and compares.
module tb_multicycle_controller;
  import controller_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:12] Instr = 20'h0;
  logic [3:0]   ALUFlags = 4'h0;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0]   state_o;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [19:0] q_exp[$];
  string       q_nm[$];
  logic [19:0] w_act;

  assign w_act = {state_o, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  // record: {state, PCW, MW, RW, IRW, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl}
  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, mw, rw, irw, adr, srca,
                                     input logic [1:0] res, srcb, imm, rsrc, aluc);
    return {st, pcw, mw, rw, irw, adr, srca, res, srcb, imm, rsrc, aluc};
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    string       n;
    logic [19:0] e;
    if (q_exp.size() != 0) begin
      n = q_nm.pop_front();
      e = q_exp.pop_front();
      chk(n, w_act, e);
    end
  end

  task automatic ex(input string nm, input logic [19:0] v);
    q_nm.push_back(nm);
    q_exp.push_back(v);
  endtask

  task automatic fd(input string nm, input logic [1:0] rs);
    ex({nm, "_fetch"},  mk(S_FETCH, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, rs, 2'b00));
    ex({nm, "_decode"}, mk(S_DECODE, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, rs, 2'b00));
  endtask

  task automatic go(input logic [19:0] ins, input logic [3:0] fl, input int n);
    Instr = ins;
    ALUFlags = fl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dp(input string nm, input logic [19:0] ins, input logic [3:0] fl,
                    input logic imm, input logic [1:0] aluc, input logic pcw, input logic rw);
    fd(nm, 2'b00);
    if (imm) ex({nm, "_exi"}, mk(S_EXECUTEI, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, aluc));
    else     ex({nm, "_exr"}, mk(S_EXECUTER, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, aluc));
    ex({nm, "_wb"}, mk(S_ALUWB, pcw, 0, rw, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    go(ins, fl, 4);
  endtask

  task automatic br(input string nm, input logic [19:0] ins, input logic take);
    fd(nm, 2'b01);
    ex({nm, "_br"}, mk(S_BRANCH, take, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00));
    go(ins, 4'h0, 3);
  endtask

  task automatic ldr(input string nm, input logic [19:0] ins, input logic [1:0] aluc);
    fd(nm, 2'b00);
    ex({nm, "_madr"}, mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, aluc));
    ex({nm, "_mrd"},  mk(S_MEMREAD, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    ex({nm, "_mwb"},  mk(S_MEMWB, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    go(ins, 4'h0, 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_state", w_act, 20'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    dp("add_imm",  20'hE2802, 4'h0, 1, 2'b00, 0, 1);
    dp("add_pc",   20'hE280F, 4'h0, 1, 2'b00, 1, 1);
    dp("subs_z",   20'hE0558, 4'h4, 0, 2'b01, 0, 1);
    br("beq_t",    20'h0A000, 1);
    dp("subs_nz",  20'hE0558, 4'h0, 0, 2'b01, 0, 1);
    br("beq_nt",   20'h0A000, 0);
    dp("orr_nos",  20'hE1800, 4'hF, 0, 2'b11, 0, 1);
    br("beq_nt2",  20'h0A000, 0);
    dp("and_nos",  20'hE0000, 4'hF, 0, 2'b10, 0, 1);
    dp("eor_dflt", 20'hE0200, 4'hF, 0, 2'b00, 0, 1);

    ldr("ldr_up", 20'hE5912, 2'b00);
    fd("str", 2'b10);
    ex("str_madr", mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00));
    ex("str_mwr",  mk(S_MEMWRITE, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00));
    go(20'hE5812, 4'h0, 4);
    ldr("ldr_dn", 20'hE5112, 2'b01);

    fd("op11", 2'b00);
    go(20'hEC000, 4'h0, 2);
    dp("add_nv",   20'hF2802, 4'h0, 1, 2'b00, 0, 0);

    dp("subs_c",   20'hE0558, 4'h2, 0, 2'b01, 0, 1);
    br("bcs_t",    20'h2A000, 1);
    dp("ands_cv",  20'hE0100, 4'h1, 0, 2'b10, 0, 1);
    br("bvs_nt",   20'h6A000, 0);
    br("bcs_t2",   20'h2A000, 1);

    fd("rst", 2'b00);
    ex("rst_madr", mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
    go(20'hE5912, 4'h0, 2);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_async", w_act, 20'h0);
    @(posedge clk); #1;
    chk("rst_hold", w_act, 20'h0);
    reset = 1'b1;
    br("bcs_after_rst", 20'h2A000, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL queue_drained actual=%0d required=0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
